// File: rtl/ldpc_encoder_pkg.sv
// Shared LDPC encoder definitions: merge FSM states and default codeword geometry.
package ldpc_encoder_pkg;

  localparam int LDPC_SYS_WORDS = 2048;
  localparam int LDPC_PAR_WORDS = 2048;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SYS  = 2'd1,
    ST_PAR  = 2'd2
  } merge_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ldpc_skid_buffer.sv
// Two-entry ready/valid stage: registered output plus one spare register, 1-cycle latency.
// Ready depends only on occupancy, so i_ready never reaches o_ready combinationally.
module ldpc_skid_buffer #(
  parameter int W = 9
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [W-1:0] spare_data;
  logic         spare_valid;
  logic         push;
  logic         pop;

  assign o_ready = !spare_valid;
  assign push    = i_valid && !spare_valid;
  assign pop     = o_valid && i_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      spare_data  <= '0;
      spare_valid <= 1'b0;
    end else if (pop || !o_valid) begin
      // Output slot frees up: the older spare word always goes first.
      if (spare_valid) begin
        o_data      <= spare_data;
        o_valid     <= 1'b1;
        spare_valid <= push;
        if (push) spare_data <= i_data;
      end else begin
        o_valid <= push;
        if (push) o_data <= i_data;
      end
    end else if (push) begin
      spare_data  <= i_data;
      spare_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/ldpc_codeword_merge.sv
// Merges delayed systematic words then parity words into one codeword stream with a last marker.
// Optional o_frame_count port under LDPC_MERGE_FRAME_COUNT_EN.
module ldpc_codeword_merge
  import ldpc_encoder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SYS_WORDS = LDPC_SYS_WORDS,
  parameter int PAR_WORDS = LDPC_PAR_WORDS
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sys_data,
  input  logic             i_sys_valid,
  output logic             o_sys_ready,
  input  logic [WIDTH-1:0] i_par_data,
  input  logic             i_par_valid,
  output logic             o_par_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_out_last,
  input  logic             i_out_ready
`ifdef LDPC_MERGE_FRAME_COUNT_EN
  ,
  output logic [31:0]      o_frame_count
`endif
);

  localparam int CNT_W = $clog2(max_int(SYS_WORDS, PAR_WORDS));
  localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_WORDS - 1);
  localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(PAR_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  merge_state_t     state;
  logic [CNT_W-1:0] word_cnt;
  logic             buf_ready;
  logic             sys_xfer;
  logic             par_xfer;
  logic             in_valid;
  logic [WIDTH:0]   in_payload;
  logic [WIDTH:0]   out_payload;

  assign o_sys_ready = (state == ST_SYS) && buf_ready;
  assign o_par_ready = (state == ST_PAR) && buf_ready;
  assign sys_xfer    = i_sys_valid && o_sys_ready;
  assign par_xfer    = i_par_valid && o_par_ready;
  assign in_valid    = sys_xfer || par_xfer;

  always_comb begin
    in_payload = {1'b0, i_sys_data};
    if (state == ST_PAR) in_payload = {word_cnt == PAR_LAST, i_par_data};
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ST_INIT;
      word_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: state <= ST_SYS;
        ST_SYS: if (sys_xfer) begin
          if (word_cnt == SYS_LAST) begin
            word_cnt <= '0;
            state    <= ST_PAR;
          end else begin
            word_cnt <= word_cnt + CNT_ONE;
          end
        end
        ST_PAR: if (par_xfer) begin
          if (word_cnt == PAR_LAST) begin
            word_cnt <= '0;
            state    <= ST_SYS;
          end else begin
            word_cnt <= word_cnt + CNT_ONE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  ldpc_skid_buffer #(.W(WIDTH + 1)) u_skid (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_data  (in_payload),
    .i_valid (in_valid),
    .o_ready (buf_ready),
    .o_data  (out_payload),
    .o_valid (o_out_valid),
    .i_ready (i_out_ready)
  );

  assign o_out_data = out_payload[WIDTH-1:0];
  assign o_out_last = out_payload[WIDTH];

`ifdef LDPC_MERGE_FRAME_COUNT_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) o_frame_count <= '0;
    else if (o_out_valid && i_out_ready && o_out_last) o_frame_count <= o_frame_count + 32'd1;
  end
`endif

endmodule
